// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - sequential double-dabble binary-to-BCD converter for the multiplier product
// Optional macro PRODUCT_BCD_BLANK_EN adds the registered leading-zero blank output.
module product_bcd_converter #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
`ifdef PRODUCT_BCD_BLANK_EN
  output logic [DIGITS-1:0]     blank,
`endif
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                 state, state_next;
  logic [IN_WIDTH-1:0]    shreg;
  logic [SW-1:0]          scratch;
  logic [SW-1:0]          adjusted;
  logic [SW-1:0]          scratch_next;
  logic [SW+IN_WIDTH-1:0] shifted;
  logic [CW-1:0]          count;
  logic                   last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign last = (count == CW'(1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONVERT);
  end

  // Add-3 on every digit >= 5 so the following shift carries correctly into the next decade.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  assign shifted      = {adjusted, shreg} << 1;
  assign scratch_next = shifted[SW+IN_WIDTH-1:IN_WIDTH];

`ifdef PRODUCT_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;

  always_comb begin
    blank_next = '0;
    blank_next[DIGITS-1] = (scratch_next[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      blank_next[i] = blank_next[i+1] && (scratch_next[4*i +: 4] == 4'd0);
    end
    blank_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      blank <= '0;
    else if (state == CONVERT && last)
      blank <= blank_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            count   <= CW'(IN_WIDTH);
          end
        end
        CONVERT: begin
          shreg   <= shifted[IN_WIDTH-1:0];
          scratch <= scratch_next;
          count   <= count - CW'(1);
          // bcd only moves on completion so the display never sees partial digits.
          if (last) begin
            bcd  <= scratch_next;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// tb/tb_product_bcd_converter.sv - scoreboard bench for product_bcd_converter (optional PRODUCT_BCD_BLANK_EN)
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'd0;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
`ifdef PRODUCT_BCD_BLANK_EN
  logic [2:0]  blank;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  product_bcd_converter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef PRODUCT_BCD_BLANK_EN
    .blank (blank),
`endif
    .bcd   (bcd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [2:0] blank_of(input int v);
    logic [2:0] b;
    b    = 3'b000;
    b[2] = (v / 100) == 0;
    b[1] = b[2] && ((v / 10) % 10) == 0;
    return b;
  endfunction

  // Scoreboard: each done pops the bin value queued when its start was driven.
  always @(negedge clk) begin
    if (done) begin
      check("done_not_busy", 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        int v;
        v = exp_q.pop_front();
        check("bcd", 32'(bcd), 32'(bcd_of(v)));
`ifdef PRODUCT_BCD_BLANK_EN
        check("blank", 32'(blank), 32'(blank_of(v)));
`endif
      end
    end
  end

  // Drives start for one edge; leaves the caller 1 time unit after that edge.
  task automatic start_conv(input int v, input bit push);
    start = 1'b1;
    bin   = 8'(v);
    if (push) exp_q.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit chk_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) seen = 1;
      else if (chk_lat && lat < 8) check("busy_mid", 32'(busy), 32'd1);
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
    if (chk_lat) check("latency", 32'(lat), 32'd8);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic run_conv(input int v);
    start_conv(v, 1'b1);
    wait_done(1'b1);
  endtask

  initial begin
    // T1: reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_bcd", 32'(bcd), 32'd0);
`ifdef PRODUCT_BCD_BLANK_EN
      check("idle_blank", 32'(blank), 32'd0);
`endif
    end

    // T2: full-scale product, done one cycle wide
    run_conv(225);
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
    check("bcd_hold", 32'(bcd), 32'h225);

    // T3: zero then small value
    run_conv(0);
    run_conv(6);

    // T4: start while busy is ignored
    @(negedge clk);
    start_conv(132, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start_conv(56, 1'b0);
    wait_done(1'b0);
    repeat (12) @(negedge clk);
    check("ignored_hold", 32'(bcd), 32'h132);

    // T5: start accepted in the done cycle
    run_conv(36);
    check("b2b_first", 32'(bcd), 32'h036);
    start_conv(56, 1'b1);
    @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(1'b0);

    // T6: reset mid-conversion aborts
    @(negedge clk);
    start_conv(99, 1'b1);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done_bcd", 32'(bcd), 32'd0);
    run_conv(99);

    // Sweep every multiplier product back to back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_conv(a * b);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
